// File: rtl/mc10_pkg.sv
// Shared types for the MC-10 video RAM arbiter.
package mc10_pkg;

  localparam int VRAM_AW = 12;

  typedef enum logic [2:0] {
    IDLE,
    VDG_A,
    VDG_D,
    CPU_A,
    CPU_D
  } arb_state_t;

endpackage

// File: rtl/mc10_req_latch.sv
// Pending flag plus captured request fields for one VRAM requester.
module mc10_req_latch #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         pend,
  output logic [W-1:0] q
);

  logic take;

  // A request landing in the ack cycle re-arms the flag instead of being lost.
  assign take = req && (!pend || clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 1'b0;
      q    <= '0;
    end else if (take) begin
      pend <= 1'b1;
      q    <= d;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/mc10_vram_arbiter.sv
// Two-slot VRAM arbiter: VDG display fetch has priority, CPU starvation is bounded.
module mc10_vram_arbiter
  import mc10_pkg::*;
#(
  parameter int AW         = VRAM_AW,
  parameter int MAX_STARVE = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic          cpu_wait,
  input  logic          vdg_req,
  input  logic [AW-1:0] vdg_addr,
  output logic [7:0]    vdg_dout,
  output logic          vdg_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
);

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  arb_state_t    state, nxt;
  logic          cpu_pend, vdg_pend;
  logic [AW+8:0] cpu_fld;
  logic [AW-1:0] vdg_fld;
  logic          cpu_we_q;
  logic [7:0]    cpu_din_q;
  logic [AW-1:0] cpu_addr_q;
  logic [3:0]    starve;
  logic          grant_vdg, grant_cpu, cpu_rd_ack;
  logic [7:0]    cpu_dq, vdg_dq;

  mc10_req_latch #(.W(AW + 9)) u_cpu_lat (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (cpu_req),
    .clr     (cpu_ack),
    .d       ({cpu_we, cpu_din, cpu_addr}),
    .pend    (cpu_pend),
    .q       (cpu_fld)
  );

  // VDG only reads, so its latch carries the address alone.
  mc10_req_latch #(.W(AW)) u_vdg_lat (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (vdg_req),
    .clr     (vdg_ack),
    .d       (vdg_addr),
    .pend    (vdg_pend),
    .q       (vdg_fld)
  );

  assign {cpu_we_q, cpu_din_q, cpu_addr_q} = cpu_fld;

  always_comb begin
    nxt       = state;
    grant_vdg = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      IDLE: if (ce) begin
        if (vdg_pend && (!cpu_pend || starve < STARVE_MAX)) begin
          nxt       = VDG_A;
          grant_vdg = 1'b1;
        end else if (cpu_pend) begin
          nxt       = CPU_A;
          grant_cpu = 1'b1;
        end
      end
      VDG_A:   nxt = VDG_D;
      VDG_D:   nxt = IDLE;
      CPU_A:   nxt = CPU_D;
      CPU_D:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign cpu_ack    = (state == CPU_D);
  assign vdg_ack    = (state == VDG_D);
  assign ram_we     = (state == CPU_A) && cpu_we_q;
  assign cpu_wait   = cpu_pend;
  assign cpu_rd_ack = cpu_ack && !cpu_we_q;

  // RAM data bypasses straight out during the ack cycle, then the copy holds it.
  assign cpu_dout = cpu_rd_ack ? ram_dout : cpu_dq;
  assign vdg_dout = vdg_ack    ? ram_dout : vdg_dq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ram_addr <= '0;
      ram_din  <= '0;
      starve   <= '0;
      cpu_dq   <= '0;
      vdg_dq   <= '0;
    end else begin
      state <= nxt;
      if (grant_vdg) ram_addr <= vdg_fld;
      if (grant_cpu) begin
        ram_addr <= cpu_addr_q;
        ram_din  <= cpu_din_q;
      end
      if (!cpu_pend || grant_cpu)
        starve <= '0;
      else if (grant_vdg && starve < STARVE_MAX)
        starve <= starve + 4'd1;
      if (cpu_rd_ack) cpu_dq <= ram_dout;
      if (vdg_ack)    vdg_dq <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Self-checking bench: slot-timeline model compared every cycle, plus directed literal checks.
module tb_mc10_vram_arbiter;

  localparam int AW  = 12;
  localparam int MAX = 3;

  logic          clk, reset_n, ce;
  logic          cpu_req, cpu_we, vdg_req;
  logic [AW-1:0] cpu_addr, vdg_addr, ram_addr;
  logic [7:0]    cpu_din, cpu_dout, vdg_dout, ram_din;
  logic [7:0]    ram_dout = 8'h00;
  logic          cpu_ack, cpu_wait, vdg_ack, ram_we;

  int n_cmp = 0;
  int n_bad = 0;

  mc10_vram_arbiter #(.AW(AW), .MAX_STARVE(MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .cpu_ack  (cpu_ack),
    .cpu_wait (cpu_wait),
    .vdg_req  (vdg_req),
    .vdg_addr (vdg_addr),
    .vdg_dout (vdg_dout),
    .vdg_ack  (vdg_ack),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    logic [7:0] lo;
    lo = a[7:0];
    return (a == 32'h123) ? 8'hA5 : (lo ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Synchronous VRAM: read data appears the cycle after the address.
  logic [7:0] ram [4096];
  bit ram_init = 0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] = pat(i);
      ram_init = 1;
    end
    ram_dout <= ram[ram_addr];
    if (ram_we) ram[ram_addr] = ram_din;
  end

  // Model: pending requests plus the current slot (owner 1=VDG 2=CPU, phase 1=addr 2=data).
  logic [7:0]    mem [4096];
  bit            m_init = 0;
  bit            m_cp, m_cw, m_vp;
  logic [AW-1:0] m_ca, m_va, m_ra;
  logic [7:0]    m_cd, m_rd, m_cdo, m_vdo;
  int            m_slot, m_ph, m_st;

  always @(posedge clk or negedge reset_n) begin
    int  pick;
    bit  c_ack, v_ack;
    if (!m_init) begin
      for (int i = 0; i < 4096; i++) mem[i] = pat(i);
      m_init = 1;
    end
    if (!reset_n) begin
      m_cp = 0; m_cw = 0; m_vp = 0; m_ca = '0; m_va = '0; m_ra = '0;
      m_cd = '0; m_rd = '0; m_cdo = '0; m_vdo = '0;
      m_slot = 0; m_ph = 0; m_st = 0;
    end else begin
      c_ack = (m_slot == 2 && m_ph == 2);
      v_ack = (m_slot == 1 && m_ph == 2);
      if (c_ack && !m_cw) m_cdo = mem[m_ca];
      if (v_ack) m_vdo = mem[m_va];
      if (m_slot == 2 && m_ph == 1 && m_cw) mem[m_ca] = m_cd;
      pick = 0;
      if (m_slot == 0 && ce) begin
        if (m_vp && (!m_cp || m_st < MAX)) pick = 1;
        else if (m_cp) pick = 2;
      end
      if (!m_cp || pick == 2) m_st = 0;
      else if (pick == 1 && m_st < MAX) m_st++;
      if (m_slot != 0) begin
        if (m_ph == 1) m_ph = 2;
        else m_slot = 0;
      end else if (pick != 0) begin
        m_slot = pick;
        m_ph   = 1;
        if (pick == 1) m_ra = m_va;
        else begin
          m_ra = m_ca;
          m_rd = m_cd;
        end
      end
      if (cpu_req && (!m_cp || c_ack)) begin
        m_cp = 1; m_ca = cpu_addr; m_cw = cpu_we; m_cd = cpu_din;
      end else if (c_ack) m_cp = 0;
      if (vdg_req && (!m_vp || v_ack)) begin
        m_vp = 1; m_va = vdg_addr;
      end else if (v_ack) m_vp = 0;
    end
  end

  always @(posedge clk) begin
    bit e_cack, e_vack;
    #1;
    if (reset_n) begin
      e_cack = (m_slot == 2 && m_ph == 2);
      e_vack = (m_slot == 1 && m_ph == 2);
      chk("cmp_cpu_ack",  32'(cpu_ack),  32'(e_cack));
      chk("cmp_vdg_ack",  32'(vdg_ack),  32'(e_vack));
      chk("cmp_cpu_wait", 32'(cpu_wait), 32'(m_cp));
      chk("cmp_ram_we",   32'(ram_we),   32'(m_slot == 2 && m_ph == 1 && m_cw));
      chk("cmp_ram_addr", 32'(ram_addr), 32'(m_ra));
      chk("cmp_ram_din",  32'(ram_din),  32'(m_rd));
      chk("cmp_cpu_dout", 32'(cpu_dout), 32'((e_cack && !m_cw) ? mem[m_ca] : m_cdo));
      chk("cmp_vdg_dout", 32'(vdg_dout), 32'(e_vack ? mem[m_va] : m_vdo));
    end
  end

  task automatic wait_cack(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (cpu_ack) ok = 1;
      else @(negedge clk);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    int         nwe, tv, tc, nev, nv, gap;
    bit         saw, sawack;
    logic [7:0] vd, cd;
    logic [7:0] seq [8];
    logic [39:0] exp_seq;

    reset_n = 0; ce = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    vdg_req = 0; vdg_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_ack",  32'(cpu_ack),  0);
    chk("rst_vdg_ack",  32'(vdg_ack),  0);
    chk("rst_cpu_wait", 32'(cpu_wait), 0);
    chk("rst_ram_we",   32'(ram_we),   0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 0);
    chk("rst_vdg_dout", 32'(vdg_dout), 0);
    reset_n = 1;
    @(negedge clk);

    // CPU read of preloaded 0xA5
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123;
    @(negedge clk); cpu_req = 0;
    chk("rd_wait_rise", 32'(cpu_wait), 1);
    chk("rd_no_ack", 32'(cpu_ack), 0);
    @(negedge clk);
    chk("rd_ram_addr", 32'(ram_addr), 32'h123);
    chk("rd_ram_we", 32'(ram_we), 0);
    @(negedge clk);
    chk("rd_ack", 32'(cpu_ack), 1);
    chk("rd_dout", 32'(cpu_dout), 32'hA5);
    chk("rd_wait_ack", 32'(cpu_wait), 1);
    @(negedge clk);
    chk("rd_ack_once", 32'(cpu_ack), 0);
    chk("rd_dout_hold", 32'(cpu_dout), 32'hA5);
    chk("rd_wait_fall", 32'(cpu_wait), 0);
    chk("model_rd", 32'(m_cdo), 32'hA5);

    // CPU write to the top address
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'hFFF; cpu_din = 8'h3C;
    @(negedge clk); cpu_req = 0; cpu_we = 0;
    nwe = 0; sawack = 0;
    for (int i = 0; i < 6; i++) begin
      if (ram_we) begin
        nwe++;
        chk("wr_ram_addr", 32'(ram_addr), 32'hFFF);
        chk("wr_ram_din", 32'(ram_din), 32'h3C);
      end
      if (cpu_ack) begin
        sawack = 1;
        chk("wr_dout_keep", 32'(cpu_dout), 32'hA5);
      end
      @(negedge clk);
    end
    chk("wr_we_cycles", 32'(nwe), 1);
    chk("wr_acked", 32'(sawack), 1);
    cpu_req = 1; cpu_addr = 12'hFFF;
    @(negedge clk); cpu_req = 0;
    wait_cack("rb_timeout");
    chk("rb_dout", 32'(cpu_dout), 32'h3C);
    @(negedge clk);

    // ce low holds arbitration in IDLE
    ce = 0; cpu_req = 1; cpu_addr = 12'h0AB;
    @(negedge clk); cpu_req = 0;
    saw = 0;
    repeat (4) begin
      if (cpu_ack || ram_addr == 12'h0AB) saw = 1;
      @(negedge clk);
    end
    chk("ce_no_grant", 32'(saw), 0);
    chk("ce_wait", 32'(cpu_wait), 1);
    ce = 1;
    wait_cack("ce_timeout");
    chk("ce_dout", 32'(cpu_dout), 32'hF1);
    @(negedge clk);

    // simultaneous requests: VDG first, CPU three cycles later
    cpu_req = 1; cpu_addr = 12'h010; vdg_req = 1; vdg_addr = 12'h020;
    @(negedge clk); cpu_req = 0; vdg_req = 0;
    tv = -1; tc = -1; vd = '0; cd = '0;
    for (int i = 0; i < 20; i++) begin
      if (vdg_ack && tv < 0) begin tv = i; vd = vdg_dout; end
      if (cpu_ack && tc < 0) begin tc = i; cd = cpu_dout; end
      @(negedge clk);
    end
    chk("sim_vdg_time", 32'(tv), 2);
    chk("sim_gap", 32'(tc - tv), 3);
    chk("sim_vdg_dout", 32'(vd), 32'h7A);
    chk("sim_cpu_dout", 32'(cd), 32'h4A);

    // starvation bound: VDG re-requests in every ack cycle
    cpu_req = 1; cpu_addr = 12'h033; vdg_req = 1; vdg_addr = 12'h044;
    @(negedge clk); cpu_req = 0; vdg_req = 0;
    nev = 0; nv = 0;
    for (int i = 0; i < 40; i++) begin
      vdg_req = 0;
      if (vdg_ack) begin
        if (nev < 8) seq[nev] = "V";
        nev++; nv++;
        if (nv < 4) begin vdg_req = 1; vdg_addr = 12'(12'h044 + nv); end
      end
      if (cpu_ack) begin
        if (nev < 8) seq[nev] = "C";
        nev++;
      end
      @(negedge clk);
    end
    vdg_req = 0;
    exp_seq = "VVVCV";
    chk("stv_events", 32'(nev), 5);
    for (int k = 0; k < 5; k++)
      chk("stv_order", 32'(seq[k]), 32'(exp_seq[8*(4-k) +: 8]));

    // second request while pending is dropped; request in ack cycle is kept
    cpu_req = 1; cpu_addr = 12'h200;
    @(negedge clk); cpu_addr = 12'h555;
    @(negedge clk); cpu_req = 0;
    wait_cack("pr_timeout");
    chk("pr_dout", 32'(cpu_dout), 32'h5A);
    chk("pr_ram_addr", 32'(ram_addr), 32'h200);
    cpu_req = 1; cpu_addr = 12'h0C3;
    @(negedge clk); cpu_req = 0;
    chk("pr_wait_kept", 32'(cpu_wait), 1);
    gap = 1;
    while (!cpu_ack && gap < 20) begin @(negedge clk); gap++; end
    chk("pr_gap", 32'(gap), 3);
    chk("pr2_dout", 32'(cpu_dout), 32'h99);
    @(negedge clk);

    // reset while a write sits in its address cycle
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h0F0; cpu_din = 8'h66;
    @(negedge clk); cpu_req = 0; cpu_we = 0;
    saw = 0;
    for (int i = 0; i < 10 && !saw; i++) begin
      if (ram_we) saw = 1;
      else @(negedge clk);
    end
    chk("mr_reach_we", 32'(saw), 1);
    #1 reset_n = 0;
    #1;
    chk("mr_we_drop", 32'(ram_we), 0);
    chk("mr_ack", 32'(cpu_ack), 0);
    chk("mr_wait", 32'(cpu_wait), 0);
    chk("mr_ram_addr", 32'(ram_addr), 0);
    chk("mr_ram_din", 32'(ram_din), 0);
    chk("mr_cpu_dout", 32'(cpu_dout), 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    saw = 0;
    repeat (4) begin
      if (cpu_ack || cpu_wait) saw = 1;
      @(negedge clk);
    end
    chk("mr_no_ack", 32'(saw), 0);
    cpu_req = 1; cpu_addr = 12'h0F0;
    @(negedge clk); cpu_req = 0;
    wait_cack("mr_rb_timeout");
    chk("mr_rb_dout", 32'(cpu_dout), 32'hAA);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
